vol_ramp_stage: RTL and testbench

- Per-channel digital volume / soft-mute stage between resample_pipeline and dac_drv, in the clk491520 domain.
- Forwards dac_drv sample requests upstream and scales each returned sample by a per-channel gain.
- Gain ramps linearly toward a CSR-programmed target, so volume changes and mutes do not click.
- Uses the codebase's pop/ack per-channel handshake on both sides.

---
 rtl/vol_ramp_stage_if.sv | 31 +++
 rtl/vol_ramp_stage.sv | 116 +++++++++++
 tb/tb_vol_ramp_stage.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/vol_ramp_stage_if.sv
// vol_ramp_stage_if: pop/ack sample bus around vol_ramp_stage.
// Carries the per-channel volume words plus both handshake sides:
//   vol_i   NUM_CH*32  per-channel control: bit31 mute, bits15:0 target gain (Q1.15)
//   pop_o   NUM_CH     sample request forwarded upstream
//   ack_i   NUM_CH     upstream sample valid
//   data_i  NUM_CH*24  upstream samples, two's complement
//   pop_i   NUM_CH     sample request from downstream
//   ack_o   NUM_CH     scaled sample valid (one-hot pulse)
//   data_o  24         scaled sample for the flagged channel
// slave is the stage's view, master the surrounding environment.
interface vol_ramp_stage_if #(
    parameter int NUM_CH = 2
);
    logic [NUM_CH*32-1:0] vol_i;
    logic [NUM_CH-1:0]    pop_o;
    logic [NUM_CH-1:0]    ack_i;
    logic [NUM_CH*24-1:0] data_i;
    logic [NUM_CH-1:0]    pop_i;
    logic [NUM_CH-1:0]    ack_o;
    logic [23:0]          data_o;

    modport slave (
        input  vol_i, ack_i, data_i, pop_i,
        output pop_o, ack_o, data_o
    );

    modport master (
        output vol_i, ack_i, data_i, pop_i,
        input  pop_o, ack_o, data_o
    );
endinterface

// File: rtl/vol_ramp_stage.sv
// vol_ramp_stage: per-channel digital volume / soft-mute stage.
// Forwards downstream pops upstream, captures returned samples and scales
// each by a per-channel gain that ramps by RAMP_STEP per processed sample
// toward the programmed target (0 when muted).
// Ports:
//   clk     system clock
//   rst     synchronous active-high reset
//   rst_ch  per-channel synchronous clear of gain and pending sample
//   bus     vol_ramp_stage_if.slave (vol_i, pop/ack/data on both sides)
module vol_ramp_stage #(
    parameter int          NUM_CH    = 2,
    parameter logic [15:0] RAMP_STEP = 16'h0100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] rst_ch,
    vol_ramp_stage_if.slave   bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [23:0]       hold     [NUM_CH];
    logic [15:0]       cur_gain [NUM_CH];
    logic [NUM_CH-1:0] pend;

    logic              iss_valid;
    logic [CH_W-1:0]   iss_ch;
    logic [15:0]       iss_gain;
    logic [15:0]       nxt_gain;
    logic [16:0]       eff;
    logic [16:0]       up;
    logic signed [40:0] prod;

    logic              s1_valid;
    logic [CH_W-1:0]   s1_ch;
    logic signed [40:0] s1_prod;
    logic signed [40:0] q;
    logic [23:0]       sat;

    // Lowest pending channel wins; a channel being cleared this cycle is skipped.
    always_comb begin
        iss_valid = 1'b0;
        iss_ch    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (pend[i] && !rst_ch[i] && !iss_valid) begin
                iss_valid = 1'b1;
                iss_ch    = CH_W'(i);
            end
        end
    end

    // Product uses the gain before this sample's ramp update.
    always_comb begin
        iss_gain = cur_gain[iss_ch];
        eff      = bus.vol_i[32*iss_ch+31] ? '0 : {1'b0, bus.vol_i[32*iss_ch +: 16]};
        up       = {1'b0, iss_gain} + {1'b0, RAMP_STEP};
        nxt_gain = iss_gain;
        if ({1'b0, iss_gain} < eff) begin
            nxt_gain = (up > eff) ? eff[15:0] : up[15:0];
        end else if ({1'b0, iss_gain} > eff) begin
            nxt_gain = ({1'b0, iss_gain} >= eff + {1'b0, RAMP_STEP})
                     ? iss_gain - RAMP_STEP : eff[15:0];
        end
        prod = 41'($signed(hold[iss_ch])) * 41'($signed({1'b0, iss_gain}));
    end

    // Floor via arithmetic shift, then clamp to the 24-bit signed range.
    always_comb begin
        q = s1_prod >>> 15;
        if (q[40:23] == '0 || q[40:23] == '1) begin
            sat = q[23:0];
        end else begin
            sat = q[40] ? 24'h800000 : 24'h7FFFFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.pop_o  <= '0;
            bus.ack_o  <= '0;
            bus.data_o <= '0;
            pend       <= '0;
            s1_valid   <= 1'b0;
            s1_ch      <= '0;
            s1_prod    <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cur_gain[i] <= '0;
            end
        end else begin
            bus.pop_o <= bus.pop_i;
            s1_valid  <= iss_valid;
            s1_ch     <= iss_ch;
            s1_prod   <= prod;
            bus.ack_o <= '0;
            if (s1_valid) begin
                bus.ack_o[s1_ch] <= 1'b1;
                bus.data_o       <= sat;
            end
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (rst_ch[i]) begin
                    pend[i]     <= 1'b0;
                    cur_gain[i] <= '0;
                end else begin
                    if (iss_valid && iss_ch == CH_W'(i)) begin
                        pend[i]     <= 1'b0;
                        cur_gain[i] <= nxt_gain;
                    end
                    // A fresh capture overrides the issue clear for the same channel.
                    if (bus.ack_i[i]) begin
                        pend[i] <= 1'b1;
                        hold[i] <= bus.data_i[24*i +: 24];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_vol_ramp_stage.sv
// tb_vol_ramp_stage: self-checking bench for vol_ramp_stage (NUM_CH=2).
// Table-driven gain/rounding/saturation vectors, hand sequences for ramp,
// mute, contention and resets, and a randomized phase against a
// sample-level reference model of gain ramping and Q1.15 scaling.
module tb_vol_ramp_stage;
    localparam int STEP = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] rst_ch;

    always #5 clk = ~clk;

    vol_ramp_stage_if #(.NUM_CH(2)) bus ();

    vol_ramp_stage #(.NUM_CH(2), .RAMP_STEP(16'h0100)) dut (
        .clk    (clk),
        .rst    (rst),
        .rst_ch (rst_ch),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;
    int mgain [2];

    typedef struct {
        logic [31:0] vol;
        int          settle;
        logic [23:0] din;
        logic [23:0] dexp;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: out = clamp(floor(sample * gain / 2^15)), then gain moves
    // one step toward the effective target without overshooting.
    task automatic model_step(input int ch, input logic [23:0] d, output logic [23:0] e);
        longint p, qq;
        int     eff;
        p = longint'($signed(d)) * longint'(mgain[ch]);
        if (p >= 0) qq = p / 32768;
        else        qq = -((-p + 32767) / 32768);
        if (qq > 64'sd8388607)  qq = 8388607;
        if (qq < -64'sd8388608) qq = -8388608;
        e = 24'(qq);
        eff = bus.vol_i[32*ch+31] ? 0 : int'(bus.vol_i[32*ch +: 16]);
        if (mgain[ch] < eff)      mgain[ch] = (mgain[ch] + STEP > eff) ? eff : mgain[ch] + STEP;
        else if (mgain[ch] > eff) mgain[ch] = (mgain[ch] - STEP < eff) ? eff : mgain[ch] - STEP;
    endtask

    task automatic set_vol(input int ch, input logic [31:0] w);
        bus.vol_i[32*ch +: 32] = w;
    endtask

    // One isolated sample: checks latency, ack channel and model data.
    task automatic send(input int ch, input logic [23:0] d, input string name,
                        output logic [23:0] got);
        logic [23:0] e;
        int          n;
        logic        seen;
        bus.ack_i = 2'b01 << ch;
        bus.data_i[24*ch +: 24] = d;
        model_step(ch, d, e);
        tick();
        bus.ack_i = '0;
        n = 1;
        seen = 1'b0;
        while (!seen && n < 8) begin
            tick();
            n++;
            if (bus.ack_o != 0) seen = 1'b1;
        end
        check({name, "_lat"}, n, 3);
        check({name, "_ack"}, bus.ack_o, 32'(2'b01 << ch));
        check(name, bus.data_o, e);
        got = bus.data_o;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] got, d0, d1, e0, e1;
        int          expv;

        tbl[0] = '{32'h0000_8000,   0, 24'h123456, 24'h123456};
        tbl[1] = '{32'h0000_4000,  70, 24'hFFFFFF, 24'hFFFFFF};
        tbl[2] = '{32'h0000_4000,   0, 24'h000003, 24'h000001};
        tbl[3] = '{32'h0000_FFFF, 200, 24'h7FFFFF, 24'h7FFFFF};
        tbl[4] = '{32'h0000_FFFF,   0, 24'h800000, 24'h800000};
        tbl[5] = '{32'h0000_FFFF,   0, 24'h500000, 24'h7FFFFF};
        tbl[6] = '{32'h0000_8000, 140, 24'h400000, 24'h400000};

        rst = 1'b1;
        rst_ch = '0;
        bus.vol_i = '0;
        bus.ack_i = '0;
        bus.data_i = '0;
        bus.pop_i = '0;
        mgain[0] = 0;
        mgain[1] = 0;
        repeat (3) tick();
        check("rst_pop_o", bus.pop_o, 0);
        check("rst_ack_o", bus.ack_o, 0);
        check("rst_data_o", bus.data_o, 0);
        rst = 1'b0;
        tick();

        // Ramp from zero gain: k-th output is min(k-1,128) * 0x8000.
        set_vol(0, 32'h0000_8000);
        for (int k = 1; k <= 130; k++) begin
            send(0, 24'h400000, "ramp", got);
            expv = ((k - 1) < 128 ? (k - 1) : 128) * 32'h8000;
            check("ramp_formula", got, expv);
        end

        foreach (tbl[i]) begin
            set_vol(0, tbl[i].vol);
            for (int s = 0; s < tbl[i].settle; s++) begin
                send(0, 24'($urandom), "settle", got);
            end
            send(0, tbl[i].din, "vec_model", got);
            check($sformatf("vec%0d", i), got, tbl[i].dexp);
        end

        // Mute ramps down from unity one step per sample.
        set_vol(0, 32'h8000_8000);
        for (int k = 1; k <= 130; k++) begin
            send(0, 24'h400000, "mute", got);
            expv = ((129 - k) > 0 ? (129 - k) : 0) * 32'h8000;
            check("mute_formula", got, expv);
        end
        set_vol(0, 32'h0000_8000);
        send(0, 24'h400000, "unmute0", got);
        check("unmute0_formula", got, 0);
        send(0, 24'h400000, "unmute1", got);
        check("unmute1_formula", got, 32'h8000);
        for (int s = 0; s < 130; s++) send(0, 24'($urandom), "settle0", got);

        set_vol(1, 32'h0000_8000);
        for (int s = 0; s < 130; s++) send(1, 24'($urandom), "settle1", got);

        // Contention: both channels at once, serviced ch0 then ch1.
        d0 = 24'($urandom);
        d1 = 24'($urandom);
        bus.ack_i = 2'b11;
        bus.data_i = {d1, d0};
        bus.pop_i = 2'b10;
        model_step(0, d0, e0);
        model_step(1, d1, e1);
        tick();
        bus.ack_i = '0;
        bus.pop_i = '0;
        check("cont_pop_o", bus.pop_o, 2'b10);
        tick();
        check("cont_t2_ack", bus.ack_o, 0);
        check("cont_pop_o_clr", bus.pop_o, 0);
        tick();
        check("cont_t3_ack", bus.ack_o, 2'b01);
        check("cont_t3_data", bus.data_o, e0);
        tick();
        check("cont_t4_ack", bus.ack_o, 2'b10);
        check("cont_t4_data", bus.data_o, e1);
        tick();
        check("cont_t5_ack", bus.ack_o, 0);

        // rst_ch[1]: only ch1 restarts its ramp.
        rst_ch = 2'b10;
        tick();
        rst_ch = '0;
        mgain[1] = 0;
        send(0, 24'h400000, "rstch_ch0", got);
        check("rstch_ch0_formula", got, 24'h400000);
        send(1, 24'h400000, "rstch_ch1a", got);
        check("rstch_ch1a_formula", got, 0);
        send(1, 24'h400000, "rstch_ch1b", got);
        check("rstch_ch1b_formula", got, 24'h008000);

        // Global reset with two samples in flight drops both.
        bus.ack_i = 2'b11;
        bus.data_i = {24'h400000, 24'h400000};
        tick();
        bus.ack_i = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstfly_ack", bus.ack_o, 0);
        check("rstfly_data", bus.data_o, 0);
        mgain[0] = 0;
        mgain[1] = 0;
        for (int s = 0; s < 5; s++) begin
            tick();
            check("rstfly_quiet", bus.ack_o, 0);
        end
        send(0, 24'h400000, "rstfly_next", got);
        check("rstfly_next_formula", got, 0);

        // Randomized samples and volume changes against the model.
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                set_vol(int'($urandom_range(0, 1)),
                        {($urandom_range(0, 3) == 0), 15'($urandom), 16'($urandom)});
            end
            send(int'($urandom_range(0, 1)), 24'($urandom), "rand", got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
